// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch types and reset constant
package fetch_unit_pkg;

   localparam logic [63:0] PC_RESET_DEFAULT = 64'h8000_0000;

   typedef enum logic [1:0] {
      REQ,
      FULL,
      DISCARD
   } fetch_state_t;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] raw_instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - two-entry instruction queue, head always in slot0
module fetch_fifo
   import fetch_unit_pkg::*;
(
   input  logic         clk,
   input  logic         resetn,
   input  logic         enq,
   input  fetch_entry_t enq_entry,
   input  logic         deq,
   input  logic         flush,
   output fetch_entry_t head,
   output logic [1:0]   count
);

   fetch_entry_t slot1;
   logic         deq_eff;
   logic [1:0]   wr_idx;

   assign deq_eff = deq && (count != 2'd0);
   assign wr_idx  = count - {1'b0, deq_eff};

   // Pop shifts slot1 forward; a same-cycle push lands after the shift
   always_ff @(posedge clk) begin
      if (!resetn) begin
         count <= 2'd0;
      end else if (flush) begin
         count <= 2'd0;
      end else begin
         if (deq_eff) begin
            head <= slot1;
         end
         if (enq) begin
            if (wr_idx == 2'd0) begin
               head <= enq_entry;
            end else begin
               slot1 <= enq_entry;
            end
         end
         count <= count + {1'b0, enq} - {1'b0, deq_eff};
      end
   end

   assert property (@(posedge clk) disable iff (!resetn)
      !(enq && !flush && !deq_eff && count == 2'd2));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, single-outstanding bus FSM and decode-side queue
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = 64,
   parameter logic [ADDR_W-1:0] PC_RESET = PC_RESET_DEFAULT[ADDR_W-1:0]
) (
   input  logic              clk,
   input  logic              reset,
   output logic              ireq_valid,
   output logic [ADDR_W-1:0] ireq_addr,
   input  logic              iresp_data_ok,
   input  logic [31:0]       iresp_data,
   output logic              f_valid,
   output logic [ADDR_W-1:0] f_pc,
   output logic [31:0]       f_raw_instr,
   input  logic              d_ready,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc
);

   fetch_state_t      state, state_next;
   logic [ADDR_W-1:0] pc, pc_next, target;
   logic              enq, deq, accept;
   logic [1:0]        count, count_post;
   fetch_entry_t      enq_entry, head;

   assign target       = redirect_pc & ~ADDR_W'(3);
   assign accept       = ireq_valid && iresp_data_ok;
   assign deq          = (count != 2'd0) && d_ready && !redirect_valid;
   assign count_post   = count + 2'd1 - {1'b0, deq};
   assign enq_entry.pc = 64'(pc);
   assign enq_entry.raw_instr = iresp_data;

   always_comb begin
      state_next = state;
      pc_next    = pc;
      enq        = 1'b0;
      case (state)
         REQ: begin
            if (redirect_valid) begin
               pc_next    = target;
               state_next = (ireq_valid && !iresp_data_ok) ? DISCARD : REQ;
            end else if (accept) begin
               enq        = 1'b1;
               pc_next    = pc + ADDR_W'(4);
               state_next = (count_post == 2'd2) ? FULL : REQ;
            end
         end
         FULL: begin
            if (redirect_valid) begin
               pc_next    = target;
               state_next = REQ;
            end else if (deq) begin
               state_next = REQ;
            end
         end
         DISCARD: begin
            if (redirect_valid) begin
               pc_next = target;
            end
            if (iresp_data_ok) begin
               state_next = REQ;
            end
         end
         default: state_next = REQ;
      endcase
   end

   // The bus address is frozen while a stale request is still outstanding
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= REQ;
         pc         <= PC_RESET;
         ireq_valid <= 1'b0;
         ireq_addr  <= PC_RESET;
      end else begin
         state      <= state_next;
         pc         <= pc_next;
         ireq_valid <= (state_next != FULL);
         if (state_next != DISCARD) begin
            ireq_addr <= pc_next;
         end
      end
   end

   fetch_fifo u_fifo (
      .clk       (clk),
      .resetn    (reset),
      .enq       (enq),
      .enq_entry (enq_entry),
      .deq       (deq),
      .flush     (redirect_valid),
      .head      (head),
      .count     (count)
   );

   assign f_valid     = (count != 2'd0);
   assign f_pc        = head.pc[ADDR_W-1:0];
   assign f_raw_instr = head.raw_instr;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - fetch_unit bench against a transaction-level reference model
module tb_fetch_unit;

   localparam logic [63:0] PCR = 64'h8000_0000;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } m_ent_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;
   logic        f_valid;
   logic [63:0] f_pc;
   logic [31:0] f_raw_instr;
   logic        d_ready;
   logic        redirect_valid;
   logic [63:0] redirect_pc;

   int errors = 0;
   int checks = 0;

   m_ent_t      mq[$];
   bit          m_req_out;
   bit          m_stale;
   logic [63:0] m_req_addr;
   logic [63:0] m_pc;

   always #5 clk = ~clk;

   fetch_unit #(.ADDR_W(64), .PC_RESET(PCR)) dut (
      .clk            (clk),
      .reset          (reset),
      .ireq_valid     (ireq_valid),
      .ireq_addr      (ireq_addr),
      .iresp_data_ok  (iresp_data_ok),
      .iresp_data     (iresp_data),
      .f_valid        (f_valid),
      .f_pc           (f_pc),
      .f_raw_instr    (f_raw_instr),
      .d_ready        (d_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One request in flight, a stale flag, and a FIFO of completed fetches
   task automatic model_step();
      bit got;
      if (!reset) begin
         mq.delete();
         m_pc      = PCR;
         m_req_out = 0;
         m_stale   = 0;
      end else begin
         got = m_req_out && iresp_data_ok;
         if (redirect_valid) begin
            mq.delete();
            m_pc = redirect_pc & ~64'h3;
            if (m_req_out && !got) m_stale = 1;
            else m_req_out = 0;
         end else begin
            if (mq.size() > 0 && d_ready) void'(mq.pop_front());
            if (got) begin
               if (!m_stale) begin
                  mq.push_back('{m_req_addr, iresp_data});
                  m_pc = m_pc + 64'd4;
               end
               m_req_out = 0;
            end
         end
         if (!m_req_out && mq.size() < 2) begin
            m_req_out  = 1;
            m_req_addr = m_pc;
            m_stale    = 0;
         end
      end
   endtask

   task automatic check_all();
      chk("ireq_valid", {63'd0, ireq_valid}, {63'd0, m_req_out});
      if (m_req_out) chk("ireq_addr", ireq_addr, m_req_addr);
      chk("f_valid", {63'd0, f_valid}, {63'd0, mq.size() != 0});
      if (mq.size() != 0) begin
         chk("f_pc", f_pc, mq[0].pc);
         chk("f_raw_instr", {32'd0, f_raw_instr}, {32'd0, mq[0].instr});
      end
   endtask

   task automatic cycle(input logic rst, input logic dok, input logic [31:0] data,
                        input logic drdy, input logic redir, input logic [63:0] rpc);
      reset          = rst;
      iresp_data_ok  = dok;
      iresp_data     = data;
      d_ready        = drdy;
      redirect_valid = redir;
      redirect_pc    = rpc;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      logic dok, drdy, redir, rst;

      do_reset();
      chk("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
      chk("rst_ireq_addr", ireq_addr, 64'h8000_0000);
      chk("rst_f_valid", {63'd0, f_valid}, 64'd0);

      cycle(1, 0, 0, 1, 0, 0);
      chk("first_addr", ireq_addr, 64'h8000_0000);
      chk("first_valid", {63'd0, ireq_valid}, 64'd1);
      cycle(1, 1, 32'h0000_0013, 1, 0, 0);
      chk("lat_f_valid", {63'd0, f_valid}, 64'd1);
      chk("lat_f_pc", f_pc, 64'h8000_0000);
      chk("lat_instr", {32'd0, f_raw_instr}, 64'h13);
      chk("lat_next_addr", ireq_addr, 64'h8000_0004);

      do_reset();
      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 1, 32'h1111_1111, 0, 0, 0);
      cycle(1, 1, 32'h2222_2222, 0, 0, 0);
      chk("bp_full_valid", {63'd0, ireq_valid}, 64'd0);
      chk("bp_head_pc", f_pc, 64'h8000_0000);
      cycle(1, 0, 0, 1, 0, 0);
      chk("bp_resume_valid", {63'd0, ireq_valid}, 64'd1);
      chk("bp_resume_addr", ireq_addr, 64'h8000_0008);
      chk("bp_second_pc", f_pc, 64'h8000_0004);

      do_reset();
      cycle(1, 0, 0, 1, 0, 0);
      cycle(1, 0, 0, 1, 1, 64'h8000_0103);
      chk("disc_hold_addr", ireq_addr, 64'h8000_0000);
      cycle(1, 0, 0, 1, 0, 0);
      chk("disc_hold_addr2", ireq_addr, 64'h8000_0000);
      cycle(1, 1, 32'hdead_beef, 1, 0, 0);
      chk("disc_drop_fv", {63'd0, f_valid}, 64'd0);
      chk("disc_new_addr", ireq_addr, 64'h8000_0100);

      do_reset();
      cycle(1, 0, 0, 1, 0, 0);
      cycle(1, 1, 32'hbad0_0000, 1, 1, 64'h8000_0200);
      chk("rdok_fv", {63'd0, f_valid}, 64'd0);
      chk("rdok_addr", ireq_addr, 64'h8000_0200);

      do_reset();
      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 1, 32'h3, 0, 0, 0);
      cycle(1, 1, 32'h4, 0, 0, 0);
      cycle(1, 0, 0, 1, 1, 64'h8000_0300);
      chk("rfull_fv", {63'd0, f_valid}, 64'd0);
      chk("rfull_addr", ireq_addr, 64'h8000_0300);
      cycle(1, 1, 32'h5, 0, 0, 0);
      chk("rfull_tgt_pc", f_pc, 64'h8000_0300);

      do_reset();
      cycle(1, 0, 0, 1, 0, 0);
      cycle(1, 0, 0, 1, 1, 64'h8000_0400);
      cycle(0, 0, 0, 1, 0, 0);
      chk("rdisc_valid", {63'd0, ireq_valid}, 64'd0);
      chk("rdisc_addr", ireq_addr, 64'h8000_0000);
      chk("rdisc_fv", {63'd0, f_valid}, 64'd0);
      cycle(1, 0, 0, 1, 0, 0);
      chk("rdisc_release", ireq_addr, 64'h8000_0000);

      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(0, 199) != 0);
         dok   = ($urandom_range(0, 1) == 1);
         drdy  = ($urandom_range(0, 9) < 6);
         redir = ($urandom_range(0, 9) == 0);
         cycle(rst, dok, $urandom, drdy, redir, {32'd0, 16'h8000, 16'($urandom)});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction-fetch front end. It is the producer side of the raw-instruction interface that feeds the decoder.
- Holds the PC and issues single-outstanding requests on the instruction bus.
- Buffers returned 32-bit instructions in a 2-entry queue and presents them to decode under a valid/ready handshake.
- On a redirect from execute, it flushes the queue and discards any in-flight fetch.

## Interface
Parameters:
- PC_RESET, 64'h8000_0000, PC fetched first after reset
- ADDR_W, 64, PC/bus address width

Ports:
- clk  in  1  clock
- reset  in  1  one clock; reset is synchronous and active-low
- ireq_valid  out  1  instruction-bus request valid
- ireq_addr  out  ADDR_W  request address, word aligned
- iresp_data_ok  in  1  bus returns data this cycle, completes the request
- iresp_data  in  32  returned instruction
- f_valid  out  1  head instruction available to decode
- f_pc  out  ADDR_W  PC of head instruction
- f_raw_instr  out  32  head instruction, the decoder's raw_instr
- d_ready  in  1  decode consumes head this cycle when f_valid
- redirect_valid  in  1  control-flow redirect from execute
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] forced to 0

## Operation
- States:
  - REQ: request outstanding; ireq_valid=1.
  - FULL: queue full; ireq_valid=0.
  - DISCARD: stale request outstanding; ireq_valid=1; data dropped.
- Bus rule: once ireq_valid rises, ireq_valid and ireq_addr hold stable until the cycle iresp_data_ok=1.
  - At most one request is outstanding.
  - data_ok may arrive in the same cycle valid rises.
- REQ, on data_ok without redirect:
  - Enqueue {pc, iresp_data}; pc <= pc+4.
  - Next state is FULL if the post-update count is 2, else REQ.
- FULL: go to REQ when the post-update count is below 2, i.e. the cycle decode dequeues.
- Dequeue: when f_valid && d_ready, pop the head.
- Queue holds 2 entries; count runs 0..2; FIFO order.
  - Entering REQ only with count<2 guarantees a free slot at data_ok. Overflow is impossible, and an assertion checks it.
- Redirect has priority over enqueue and dequeue in the same cycle:
  - Queue cleared (count=0); pc <= {redirect_pc[ADDR_W-1:2],2'b00}.
  - From REQ without data_ok this cycle: next state DISCARD. The old address stays on the bus.
  - From REQ with data_ok this cycle: data dropped; next state REQ at the new pc.
  - From FULL: next state REQ at the new pc.
  - From DISCARD: pc updated; stay DISCARD.
- DISCARD, on data_ok: drop data; next state REQ. ireq_addr switches to the redirected pc.
- Outputs:
  - f_valid = count!=0.
  - f_pc and f_raw_instr come from the head entry; they are don't-care when f_valid=0.

## Timing
- Reset values, applied while reset=0 at a clock edge:
  - state=REQ, pc=PC_RESET, count=0.
  - ireq_addr=PC_RESET, f_valid=0.
  - ireq_valid=0 while reset is asserted; it rises the first cycle after release.
- Latency: data_ok in cycle t gives f_valid=1 with that instruction in cycle t+1.
- Throughput: one instruction per cycle when data_ok is asserted every cycle and d_ready=1.
- f_valid, f_pc and f_raw_instr are registered; there is no combinational path from d_ready or data_ok to them.
- ireq_valid depends only on state, which is registered.
- redirect_valid in cycle t:
  - f_valid=0 in t+1.
  - ireq_addr = redirect target in t+1, unless in DISCARD.
- Reset mid-request: the outstanding request is abandoned. The bus is assumed reset together with the unit.

## Structure
- In the shared pipes package:
  - fetch_state_t enum {REQ, FULL, DISCARD}.
  - fetch_entry_t struct {u64 pc; u32 raw_instr}.
- In common: PC_RESET default constant.
- One natural sub-module: fetch_fifo.
  - 2-entry queue of fetch_entry_t.
  - Ports: enq, deq, flush, head, count.
- fetch_unit keeps the PC, the FSM and the bus handshake.

## Test plan
- Reset then release, bus replies data_ok one cycle later with 32'h0000_0013, d_ready=1:
  - ireq_addr=0x8000_0000 on the first cycle after release.
  - Next cycle: f_valid=1, f_pc=0x8000_0000, f_raw_instr=0x0000_0013.
  - ireq_addr=0x8000_0004.
- Back-pressure: d_ready=0, data_ok every cycle:
  - Two entries queued (pc 0x8000_0000, 0x8000_0004); state FULL; ireq_valid=0.
  - d_ready=1 for one cycle: ireq_valid=1 next cycle with addr 0x8000_0008.
- Redirect while waiting, no data_ok, redirect_pc=0x8000_0103:
  - Addr stays 0x8000_0000 until data_ok; that data is dropped; f_valid stays 0.
  - Next request addr=0x8000_0100.
- Redirect same cycle as data_ok, redirect_pc=0x8000_0200:
  - Returned instruction never appears.
  - Next cycle ireq_addr=0x8000_0200; f_valid=0.
- Redirect with queue full and d_ready=1 same cycle:
  - Queue empty next cycle; no entry is popped twice.
  - Request at the target.
- Reset asserted in DISCARD:
  - Next cycle: state REQ, ireq_addr=0x8000_0000, f_valid=0, ireq_valid=0 until release.
